shift_display_driver: RTL and testbench



---
 rtl/shift_display_driver.sv | 157 +++++++++++++++
 tb/tb_shift_display_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_display_driver.sv
// Serialises {data24, data8} as a 32-bit MSB-first frame onto a 74HC595-style
// shift-register chain, then latches it, with continuous refresh while enabled.
module shift_display_driver #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned FRAME_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] data24,
    input  logic [7:0]  data8,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned FRAME_W  = 32;
    localparam int unsigned BIT_W    = 5;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned GAP_W    = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
    localparam int unsigned DIV_LAST = CLK_DIV - 1;
    localparam int unsigned GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]         state,   state_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [FRAME_W-1:0] shreg,   shreg_n;
    logic               decide;
    logic               shifting_n;
    logic               sr_data_n, sr_clk_n, sr_latch_n, busy_n, frame_done_n;
    logic               div_last;

    // Next-state, counter and next-output logic; outputs reflect the next state
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        gap_n    = gap_cnt;
        shreg_n  = shreg;
        decide   = 1'b0;
        div_last = (div_cnt == DIV_W'(DIV_LAST));

        case (state)
            S_IDLE: begin
                decide = 1'b1;
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    state_n = S_SHIFT_HI;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_n = '0;
                    if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        state_n = S_LATCH;
                        bit_n   = '0;
                    end else begin
                        state_n = S_SHIFT_LO;
                        bit_n   = bit_cnt + BIT_W'(1);
                        shreg_n = {shreg[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (div_last) begin
                    state_n = S_DONE;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            S_DONE: begin
                if (FRAME_GAP == 0) begin
                    decide = 1'b1;
                end else begin
                    state_n = S_GAP;
                    gap_n   = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    decide = 1'b1;
                    gap_n  = '0;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Snapshot decision point: start a new frame or fall back to idle
        if (decide) begin
            if (enable) begin
                state_n = S_SHIFT_LO;
                shreg_n = {data24, data8};
                div_n   = '0;
                bit_n   = '0;
                gap_n   = '0;
            end else begin
                state_n = S_IDLE;
            end
        end

        shifting_n   = (state_n == S_SHIFT_LO) || (state_n == S_SHIFT_HI);
        sr_data_n    = shifting_n & shreg_n[FRAME_W-1];
        sr_clk_n     = (state_n == S_SHIFT_HI);
        sr_latch_n   = (state_n == S_LATCH);
        busy_n       = shifting_n || (state_n == S_LATCH);
        frame_done_n = (state_n == S_DONE);
    end

    // State, counters, frame register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            sr_data    <= 1'b0;
            sr_clk     <= 1'b0;
            sr_latch   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            gap_cnt    <= gap_n;
            shreg      <= shreg_n;
            sr_data    <= sr_data_n;
            sr_clk     <= sr_clk_n;
            sr_latch   <= sr_latch_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_shift_display_driver.sv
// Bench for shift_display_driver: timeline reference model plus frame scoreboard.
module tb_shift_display_driver;

    localparam int unsigned D      = 2;
    localparam int unsigned FG     = 4;
    localparam int unsigned PERIOD = 65 * D + 1 + FG;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [23:0] data24 = 24'h0;
    logic [7:0]  data8 = 8'h0;
    logic        sr_data, sr_clk, sr_latch, busy, frame_done;

    int checks = 0;
    int errors = 0;

    shift_display_driver #(
        .CLK_DIV   (D),
        .FRAME_GAP (FG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data24     (data24),
        .data8      (data8),
        .sr_data    (sr_data),
        .sr_clk     (sr_clk),
        .sr_latch   (sr_latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: frame timeline position (cycle n after snapshot) and frame queue
    bit [31:0]   exp_q[$];
    bit          m_active = 1'b0;
    int unsigned m_t = 0;
    bit [31:0]   m_frame = 32'h0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            if (m_active && m_t <= 65 * D && exp_q.size() > 0)
                void'(exp_q.pop_back());
            m_active = 1'b0;
            m_t = 0;
        end else if (!m_active || m_t == PERIOD) begin
            if (enable) begin
                m_frame  = {data24, data8};
                exp_q.push_back(m_frame);
                m_active = 1'b1;
                m_t      = 1;
            end else begin
                m_active = 1'b0;
                m_t      = 0;
            end
        end else begin
            m_t = m_t + 1;
        end
    end

    // Monitor: per-cycle waveform check and frame capture on sr_clk rises
    bit [31:0] shbits = 32'h0;
    int        nbits = 0;
    int        frames_seen = 0;
    bit        prev_clk = 1'b0;

    always @(negedge clk) begin
        logic [4:0]  act, exp_v;
        int unsigned i, ph;
        bit [31:0]   ef;
        if (started) begin
            exp_v = 5'b0;
            if (m_active) begin
                if (m_t >= 1 && m_t <= 64 * D) begin
                    i  = (m_t - 1) / (2 * D);
                    ph = (m_t - 1) % (2 * D);
                    exp_v[4] = 1'b1;
                    exp_v[2] = (ph >= D);
                    exp_v[1] = m_frame[31 - i];
                end else if (m_t <= 65 * D) begin
                    exp_v[4] = 1'b1;
                    exp_v[3] = 1'b1;
                end else if (m_t == 65 * D + 1) begin
                    exp_v[0] = 1'b1;
                end
            end
            act = {busy, sr_latch, sr_clk, sr_data, frame_done};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL wave t=%0d active=%0b {busy,latch,clk,data,done} got=%b want=%b",
                         m_t, m_active, act, exp_v);
            end

            if (sr_clk === 1'b1 && !prev_clk) begin
                shbits = {shbits[30:0], sr_data};
                nbits++;
            end
            if (frame_done === 1'b1) begin
                checks++;
                frames_seen++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame unexpected frame_done got=%h bits=%0d want=none", shbits, nbits);
                end else begin
                    ef = exp_q.pop_front();
                    if (shbits !== ef || nbits != 32) begin
                        errors++;
                        $display("FAIL frame got=%h bits=%0d want=%h bits=32", shbits, nbits, ef);
                    end
                end
                nbits = 0;
            end
            if (rst) nbits = 0;
            prev_clk = (sr_clk === 1'b1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_t(input int unsigned n);
        bit ok = 1'b0;
        for (int c = 0; c < 4 * PERIOD; c++) begin
            @(posedge clk);
            #1;
            if (m_active && m_t == n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_cycle got=timeout want=cycle %0d", n);
        end
    endtask

    initial begin
        // Reset with enable high, then the first edge after release snapshots
        cyc(3);
        rst    = 1'b0;
        data24 = 24'hA50F3C;
        data8  = 8'h81;
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        cyc(19);
        data24 = 24'h000000;
        data8  = 8'hFF;
        cyc(PERIOD + 5);
        checks++;
        if (frames_seen != 1) begin
            errors++;
            $display("FAIL single_frame_count got=%0d want=1", frames_seen);
        end

        // Next frame takes the new data; then continuous refresh
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cyc(PERIOD);
            data24 = 24'($urandom);
            data8  = 8'($urandom);
        end

        // Enable dropped mid-frame: frame completes, then idle
        wait_t(50);
        enable = 1'b0;
        cyc(2 * PERIOD);

        // Reset mid-shift with enable held high
        enable = 1'b1;
        data24 = 24'($urandom);
        data8  = 8'($urandom);
        wait_t(100);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2 * PERIOD);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            data24 = 24'($urandom);
            data8  = 8'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            cyc(1);
        end

        rst    = 1'b0;
        enable = 1'b0;
        cyc(2 * PERIOD + 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        checks++;
        if (frames_seen < 8) begin
            errors++;
            $display("FAIL frame_total got=%0d want>=8", frames_seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
